// File: rtl/div_sequencer_if.sv
// Request/response bundle between the execute stage and the divide sequencer.
//   master : execute-stage control side (drives the request and flush, sees the response)
//   slave  : the divide sequencer
// Signals:
//   start_i/op_i/rs1_i/rs2_i/rd_i  divide request (op: 00 DIV, 01 DIVU, 10 REM, 11 REMU)
//   flush_i                        branch-unit flush
//   stall_o/busy_o                 pipeline hold / sequencer occupied
//   valid_o/result_o/rd_o          one-cycle result pulse with destination tag
interface div_sequencer_if #(parameter int XLEN = 32);
  logic            start_i;
  logic [1:0]      op_i;
  logic [XLEN-1:0] rs1_i;
  logic [XLEN-1:0] rs2_i;
  logic [4:0]      rd_i;
  logic            flush_i;
  logic            stall_o;
  logic            busy_o;
  logic            valid_o;
  logic [XLEN-1:0] result_o;
  logic [4:0]      rd_o;

  modport master (
    output start_i, op_i, rs1_i, rs2_i, rd_i, flush_i,
    input  stall_o, busy_o, valid_o, result_o, rd_o
  );

  modport slave (
    input  start_i, op_i, rs1_i, rs2_i, rd_i, flush_i,
    output stall_o, busy_o, valid_o, result_o, rd_o
  );
endinterface

// File: rtl/div_sequencer.sv
// Multi-cycle RV32M divide sequencer (DIV/DIVU/REM/REMU) for the execute stage.
// Radix-2 restoring divider, one quotient bit per cycle over 32 CALC cycles,
// result delivered in DONE as a one-cycle valid pulse with its rd tag.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-low reset
//   bus  div_sequencer_if.slave (request, flush, stall/busy, result)
// Build option:
//   DIV_FASTPATH_EN  divide-by-zero and signed overflow skip CALC and finish
//                    one cycle after start; otherwise they take the full path.
module div_sequencer #(
  parameter int XLEN = 32
) (
  input  logic             clk,
  input  logic             rst,
  div_sequencer_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  state_t state_q, state_d;

  logic            is_rem_q;   // REM/REMU: return remainder instead of quotient
  logic [4:0]      rd_q;       // tag of the op in flight
  logic            neg_quo_q;  // quotient needs negation
  logic            neg_rem_q;  // remainder needs negation
  logic            dvz_q;      // divisor was zero
  logic [XLEN-1:0] quo_q;      // dividend shifting out / quotient shifting in
  logic [XLEN:0]   rem_q;      // partial remainder
  logic [XLEN-1:0] div_q;      // divisor magnitude
  logic [4:0]      cnt_q;
  logic [XLEN-1:0] result_q;
  logic [4:0]      rd_out_q;

  // ---------------- request decode ----------------
  logic            is_signed, rs1_neg, rs2_neg, start_ok;
  logic [XLEN-1:0] abs1, abs2;

  assign is_signed = ~bus.op_i[0];
  assign rs1_neg   = is_signed & bus.rs1_i[XLEN-1];
  assign rs2_neg   = is_signed & bus.rs2_i[XLEN-1];
  assign abs1      = rs1_neg ? -bus.rs1_i : bus.rs1_i;
  assign abs2      = rs2_neg ? -bus.rs2_i : bus.rs2_i;
  assign start_ok  = (state_q == IDLE) & bus.start_i & ~bus.flush_i;

  // ---------------- special-case fast path ----------------
  logic            fast_hit;
  logic [XLEN-1:0] fast_res;

`ifdef DIV_FASTPATH_EN
  logic fast_dvz, fast_ovf;
  assign fast_dvz = (bus.rs2_i == '0);
  assign fast_ovf = is_signed & (bus.rs1_i == INT_MIN) & (bus.rs2_i == '1);
  assign fast_hit = fast_dvz | fast_ovf;
  // dvz: quotient all-ones, remainder = dividend; overflow: quotient INT_MIN, remainder 0
  assign fast_res = bus.op_i[1] ? (fast_dvz ? bus.rs1_i : '0)
                                : (fast_dvz ? '1        : INT_MIN);
`else
  assign fast_hit = 1'b0;
  assign fast_res = '0;
`endif

  // ---------------- one restoring step ----------------
  // The extra top bit on the shifted value keeps the trial difference's sign
  // bit clear of the data bits; rem < divisor always holds, so it never wraps.
  logic [XLEN+1:0] shifted, diff;
  logic [XLEN:0]   rem_nx;
  logic [XLEN-1:0] quo_nx;

  assign shifted = {rem_q, quo_q[XLEN-1]};
  assign diff    = shifted - {2'b00, div_q};
  assign rem_nx  = diff[XLEN+1] ? shifted[XLEN:0] : diff[XLEN:0];
  assign quo_nx  = {quo_q[XLEN-2:0], ~diff[XLEN+1]};

  // ---------------- sign correction on the final step ----------------
  // Divide by zero: the unsigned core already yields all-ones / |rs1|; the
  // quotient is forced so signed negation cannot disturb it, and negating
  // |rs1| by the dividend sign reproduces rs1 for the remainder.
  // INT_MIN / -1 falls out naturally: |q| = INT_MIN, signs equal, rem 0.
  logic [XLEN-1:0] quo_fix, rem_fix, calc_res;

  assign quo_fix  = dvz_q ? '1 : (neg_quo_q ? -quo_nx : quo_nx);
  assign rem_fix  = neg_rem_q ? -rem_nx[XLEN-1:0] : rem_nx[XLEN-1:0];
  assign calc_res = is_rem_q ? rem_fix : quo_fix;

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    bus.stall_o = 1'b0;
    case (state_q)
      IDLE: begin
        bus.stall_o = start_ok;
        if (start_ok) state_d = fast_hit ? DONE : CALC;
      end
      CALC: begin
        bus.stall_o = 1'b1;
        if (bus.flush_i)         state_d = IDLE;
        else if (cnt_q == 5'd31) state_d = DONE;
      end
      // flush in DONE is ignored: the result predates the branch
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------- datapath ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      is_rem_q  <= 1'b0;
      rd_q      <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dvz_q     <= 1'b0;
      quo_q     <= '0;
      rem_q     <= '0;
      div_q     <= '0;
      cnt_q     <= '0;
      result_q  <= '0;
      rd_out_q  <= '0;
    end else begin
      case (state_q)
        IDLE: if (start_ok) begin
          is_rem_q  <= bus.op_i[1];
          rd_q      <= bus.rd_i;
          neg_quo_q <= rs1_neg ^ rs2_neg;
          neg_rem_q <= rs1_neg;
          dvz_q     <= (bus.rs2_i == '0);
          quo_q     <= abs1;
          div_q     <= abs2;
          rem_q     <= '0;
          cnt_q     <= '0;
          if (fast_hit) begin
            result_q <= fast_res;
            rd_out_q <= bus.rd_i;
          end
        end
        CALC: if (!bus.flush_i) begin
          rem_q <= rem_nx;
          quo_q <= quo_nx;
          cnt_q <= cnt_q + 5'd1;
          // register the corrected result on the last step so it is
          // stable for the whole DONE cycle and held afterwards
          if (cnt_q == 5'd31) begin
            result_q <= calc_res;
            rd_out_q <= rd_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy_o   = (state_q != IDLE);
  assign bus.valid_o  = (state_q == DONE);
  assign bus.result_o = result_q;
  assign bus.rd_o     = rd_out_q;

endmodule

// File: tb/tb_div_sequencer.sv
module tb_div_sequencer;
  localparam logic [1:0] DIV = 2'b00, DIVU = 2'b01, REM = 2'b10, REMU = 2'b11;
`ifdef DIV_FASTPATH_EN
  localparam int SPLAT = 1;
`else
  localparam int SPLAT = 33;
`endif

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  div_sequencer_if #(.XLEN(32)) bus ();
  div_sequencer #(.XLEN(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // All tasks start and end at a negedge; inputs change at negedges,
  // outputs are sampled at or 1 time unit after a negedge.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, output logic stall0);
    bus.op_i = op; bus.rs1_i = a; bus.rs2_i = b; bus.rd_i = rd; bus.start_i = 1'b1;
    #1 stall0 = bus.stall_o;
    @(negedge clk);
    bus.start_i = 1'b0;
  endtask

  // Called at cycle 1; returns the cycle valid_o appeared (-1 if never) and
  // counts cycles where stall_o was not high before valid / low at valid.
  task automatic wait_valid(output int lat, output int stall_err,
                            output logic [31:0] res, output logic [4:0] rdo);
    lat = -1; stall_err = 0; res = 'x; rdo = 'x;
    for (int c = 1; c <= 60; c++) begin
      if (bus.valid_o === 1'b1) begin
        lat = c; res = bus.result_o; rdo = bus.rd_o;
        if (bus.stall_o !== 1'b0) stall_err++;
        @(negedge clk);
        break;
      end
      if (bus.stall_o !== 1'b1) stall_err++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    bus.start_i = 0; bus.flush_i = 0; bus.op_i = 0; bus.rs1_i = 0; bus.rs2_i = 0; bus.rd_i = 0;
    #12;
    total++; if (bus.stall_o !== 1'b0)  begin bad++; $display("FAIL reset_stall got=%b want=0", bus.stall_o); end
    total++; if (bus.busy_o !== 1'b0)   begin bad++; $display("FAIL reset_busy got=%b want=0", bus.busy_o); end
    total++; if (bus.valid_o !== 1'b0)  begin bad++; $display("FAIL reset_valid got=%b want=0", bus.valid_o); end
    total++; if (bus.result_o !== 32'h0) begin bad++; $display("FAIL reset_result got=%h want=0", bus.result_o); end
    total++; if (bus.rd_o !== 5'h0)     begin bad++; $display("FAIL reset_rd got=%h want=0", bus.rd_o); end
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_divu_basic;
    logic s0; int lat, se; logic [31:0] r; logic [4:0] t;
    issue(DIVU, 32'd100, 32'd7, 5'd5, s0);
    total++; if (s0 !== 1'b1) begin bad++; $display("FAIL divu_stall_c0 got=%b want=1", s0); end
    wait_valid(lat, se, r, t);
    total++; if (lat != 33) begin bad++; $display("FAIL divu_latency got=%0d want=33", lat); end
    total++; if (se != 0)   begin bad++; $display("FAIL divu_stall_window got=%0d bad cycles want=0", se); end
    total++; if (r !== 32'd14) begin bad++; $display("FAIL divu_result got=%h want=%h", r, 32'd14); end
    total++; if (t !== 5'd5)   begin bad++; $display("FAIL divu_rd got=%0d want=5", t); end
    // cycle 34: back in IDLE, outputs hold
    total++; if (bus.valid_o !== 1'b0 || bus.busy_o !== 1'b0)
      begin bad++; $display("FAIL divu_c34_idle got valid=%b busy=%b want 0 0", bus.valid_o, bus.busy_o); end
    total++; if (bus.result_o !== 32'd14 || bus.rd_o !== 5'd5)
      begin bad++; $display("FAIL divu_hold got=%h/%0d want=%h/5", bus.result_o, bus.rd_o, 32'd14); end
  endtask

  task automatic test_signed;
    logic [1:0]  op [6] = '{REM, DIV, DIV, REM, DIVU, REMU};
    logic [31:0] a  [6] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd7, 32'd7, 32'hFFFFFFFF, 32'd100};
    logic [31:0] b  [6] = '{32'd2, 32'd2, 32'hFFFFFFFE, 32'hFFFFFFFE, 32'd2, 32'd7};
    logic [31:0] e  [6] = '{32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFFD, 32'd1, 32'h7FFFFFFF, 32'd2};
    logic s0; int lat, se; logic [31:0] r; logic [4:0] t;
    for (int i = 0; i < 6; i++) begin
      issue(op[i], a[i], b[i], 5'(i + 10), s0);
      wait_valid(lat, se, r, t);
      total++; if (lat != 33 || r !== e[i] || t !== 5'(i + 10))
        begin bad++; $display("FAIL signed_vec%0d got lat=%0d res=%h rd=%0d want lat=33 res=%h rd=%0d",
                              i, lat, r, t, e[i], i + 10); end
    end
  endtask

  task automatic test_special;
    logic [1:0]  op [7] = '{DIV, REMU, REM, DIVU, DIV, REM, DIVU};
    logic [31:0] a  [7] = '{32'd123, 32'd123, 32'hFFFFFFFB, 32'd5, 32'h80000000, 32'h80000000, 32'h80000000};
    logic [31:0] b  [7] = '{32'd0, 32'd0, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] e  [7] = '{32'hFFFFFFFF, 32'd123, 32'hFFFFFFFB, 32'hFFFFFFFF, 32'h80000000, 32'd0, 32'd0};
    int          l  [7] = '{SPLAT, SPLAT, SPLAT, SPLAT, SPLAT, SPLAT, 33};
    logic s0; int lat, se; logic [31:0] r; logic [4:0] t;
    for (int i = 0; i < 7; i++) begin
      issue(op[i], a[i], b[i], 5'(i + 20), s0);
      wait_valid(lat, se, r, t);
      total++; if (lat != l[i] || se != 0 || r !== e[i] || t !== 5'(i + 20))
        begin bad++; $display("FAIL special_vec%0d got lat=%0d stallerr=%0d res=%h rd=%0d want lat=%0d stallerr=0 res=%h rd=%0d",
                              i, lat, se, r, t, l[i], e[i], i + 20); end
    end
  endtask

  task automatic test_flush;
    logic s0; int lat, se, seen; logic [31:0] r; logic [4:0] t;
    seen = 0;
    issue(DIVU, 32'd5000, 32'd3, 5'd7, s0);
    for (int c = 1; c < 10; c++) begin
      if (bus.valid_o === 1'b1) seen++;
      @(negedge clk);
    end
    bus.flush_i = 1'b1;                 // cycle 10
    @(negedge clk);
    bus.flush_i = 1'b0;                 // cycle 11
    total++; if (bus.busy_o !== 1'b0 || bus.stall_o !== 1'b0 || bus.valid_o !== 1'b0 || seen != 0)
      begin bad++; $display("FAIL flush_c11 got busy=%b stall=%b valid=%b early_valids=%0d want 0 0 0 0",
                            bus.busy_o, bus.stall_o, bus.valid_o, seen); end
    issue(DIVU, 32'd5000, 32'd3, 5'd8, s0);
    wait_valid(lat, se, r, t);
    total++; if (s0 !== 1'b1 || lat != 33 || r !== 32'd1666 || t !== 5'd8)
      begin bad++; $display("FAIL flush_restart got stall0=%b lat=%0d res=%h rd=%0d want 1 33 %h 8",
                            s0, lat, r, t, 32'd1666); end
  endtask

  task automatic test_flush_done;
    logic s0;
    issue(REMU, 32'd1000, 32'd7, 5'd3, s0);
    for (int c = 1; c < 33; c++) @(negedge clk);
    bus.flush_i = 1'b1;                 // cycle 33, DONE
    #1;
    total++; if (bus.valid_o !== 1'b1 || bus.result_o !== 32'd6 || bus.stall_o !== 1'b0)
      begin bad++; $display("FAIL flush_done got valid=%b res=%h stall=%b want 1 %h 0",
                            bus.valid_o, bus.result_o, bus.stall_o, 32'd6); end
    @(negedge clk);
    bus.flush_i = 1'b0;
  endtask

  task automatic test_back_to_back;
    logic s0; int lat, se; logic [31:0] r; logic [4:0] t;
    issue(DIVU, 32'd1000, 32'd10, 5'd1, s0);
    wait_valid(lat, se, r, t);
    total++; if (lat != 33 || r !== 32'd100) begin bad++; $display("FAIL b2b_first got lat=%0d res=%h want 33 %h", lat, r, 32'd100); end
    issue(DIV, 32'd45, 32'hFFFFFFF7, 5'd2, s0);   // cycle 34, earliest start
    wait_valid(lat, se, r, t);
    total++; if (s0 !== 1'b1 || lat != 33 || se != 0 || r !== 32'hFFFFFFFB || t !== 5'd2)
      begin bad++; $display("FAIL b2b_second got stall0=%b lat=%0d stallerr=%0d res=%h rd=%0d want 1 33 0 fffffffb 2",
                            s0, lat, se, r, t); end
  endtask

  task automatic test_reset_mid;
    logic s0; int seen;
    seen = 0;
    issue(DIVU, 32'd999, 32'd3, 5'd9, s0);
    for (int c = 1; c < 20; c++) @(negedge clk);
    rst = 1'b0;                         // cycle 20
    #1;
    total++; if (bus.stall_o !== 1'b0 || bus.busy_o !== 1'b0 || bus.valid_o !== 1'b0 ||
                 bus.result_o !== 32'h0 || bus.rd_o !== 5'h0)
      begin bad++; $display("FAIL reset_mid got stall=%b busy=%b valid=%b res=%h rd=%0d want all 0",
                            bus.stall_o, bus.busy_o, bus.valid_o, bus.result_o, bus.rd_o); end
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (bus.valid_o === 1'b1 || bus.busy_o === 1'b1) seen++;
      @(negedge clk);
    end
    total++; if (seen != 0) begin bad++; $display("FAIL reset_mid_after got active_cycles=%0d want=0", seen); end
  endtask

  task automatic test_start_flush;
    int seen;
    logic st;
    seen = 0;
    bus.op_i = DIVU; bus.rs1_i = 32'd50; bus.rs2_i = 32'd5; bus.rd_i = 5'd4;
    bus.start_i = 1'b1; bus.flush_i = 1'b1;
    #1 st = bus.stall_o;
    @(negedge clk);
    bus.start_i = 1'b0; bus.flush_i = 1'b0;
    total++; if (st !== 1'b0) begin bad++; $display("FAIL start_flush_stall got=%b want=0", st); end
    for (int c = 0; c < 40; c++) begin
      if (bus.valid_o === 1'b1 || bus.busy_o === 1'b1) seen++;
      @(negedge clk);
    end
    total++; if (seen != 0) begin bad++; $display("FAIL start_flush_idle got active_cycles=%0d want=0", seen); end
  endtask

  initial begin
    test_reset();
    test_divu_basic();
    test_signed();
    test_special();
    test_flush();
    test_flush_done();
    test_back_to_back();
    test_reset_mid();
    test_start_flush();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/div_sequencer.md
# div_sequencer

Multi-cycle integer divide sequencer for the execute stage: accepts an RV32M DIV/DIVU/REM/REMU operation, runs a radix-2 restoring divider over 32 iterations, and holds the front of the pipeline with a stall until the result is ready. It sits beside the single-cycle ALU in the execute stage. It is aborted by the branch-unit flush, and returns its result with the destination register for the execute-to-memory register.

## Interface
Parameters:
- XLEN, 32, operand/result width; the only supported value.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start_i  in  1  request a divide; sampled only in IDLE.
- op_i  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU.
- rs1_i  in  XLEN  dividend.
- rs2_i  in  XLEN  divisor.
- rd_i  in  5  destination register tag.
- flush_i  in  1  branch-unit flush; aborts an in-flight operation.
- stall_o  out  1  hold upstream stages (combinational).
- busy_o  out  1  state != IDLE (registered state decode).
- valid_o  out  1  result valid, one-cycle pulse.
- result_o  out  XLEN  quotient or remainder.
- rd_o  out  5  destination tag captured at start.

## Operation
- States: IDLE, CALC, DONE.
- IDLE:
  - start_i=1 and flush_i=0 → latch op_i, rd_i, |rs1|, |rs2|, and the sign flags. Signed ops use absolute values; unsigned ops use raw values.
  - Clear the 5-bit iteration counter and the 33-bit partial remainder, then go to CALC.
- CALC, each cycle:
  - Shift {rem, quo} left by 1 and trial-subtract the divisor from rem.
  - If the result is non-negative, keep the difference and set quo[0]=1.
  - Counter increments. At counter=31, go to DONE.
- DONE:
  - valid_o=1 and result_o is driven.
  - DIV/DIVU: quotient, negated if signed and the operand signs differ.
  - REM/REMU: remainder, negated if signed and the dividend is negative.
  - Unconditionally go to IDLE.
- Divide by zero:
  - Quotient = 0xFFFFFFFF for both signed and unsigned.
  - Remainder = rs1. The sign-correction stage forces these values.
- Signed overflow (0x80000000 / -1): quotient = 0x80000000, remainder = 0.
- stall_o = (IDLE & start_i & ~flush_i) | CALC. It is low in DONE, so the next instruction advances in the same cycle the result leaves.
- start_i in CALC or DONE is ignored; upstream is stalled, so it is not lost.
- flush_i:
  - In CALC → IDLE next cycle, with no valid_o.
  - Coincident with start_i in IDLE → start is ignored.
  - In DONE → no effect; the result is older than the flushing branch.
- Reset: state=IDLE, counter=0, all datapath registers 0.
  - Outputs at reset: stall_o=0, busy_o=0, valid_o=0, result_o=0, rd_o=0.
  - Reset mid-CALC discards the operation.

## Timing
- Cycle 0: start_i sampled in IDLE, and stall_o=1 combinationally in that cycle.
- Cycles 1–32: CALC, stall_o=1, busy_o=1.
- Cycle 33: DONE, valid_o=1, stall_o=0, result_o/rd_o valid.
- Cycle 34: IDLE. The earliest next start_i is sampled in cycle 34.
- Latency is 33 cycles from start to valid_o.
- result_o/rd_o hold their last value after DONE until the next DONE.

## Configuration
- DIV_FASTPATH_EN defined:
  - In IDLE, divisor==0 or signed overflow is detected combinationally.
  - The FSM goes straight to DONE, with the special result registered at cycle 1.
  - stall_o is high only in cycle 0. Latency is 1 cycle.
- Undefined: special cases take the full 33-cycle path, and the same special values are applied at DONE.

## Test plan
- DIVU rs1=100, rs2=7, rd=5 → valid_o at cycle 33, result_o=14, rd_o=5; stall_o high cycles 0–32 only.
- REM rs1=0xFFFFFFF9 (-7), rs2=2 → result_o=0xFFFFFFFF (-1); DIV on the same operands → 0xFFFFFFFD (-3).
- DIV rs1=123, rs2=0 → result_o=0xFFFFFFFF; REMU same → 123.
  - Valid at cycle 1 with DIV_FASTPATH_EN, at cycle 33 without.
- DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM same → 0.
- DIVU started, flush_i=1 at cycle 10 → IDLE at cycle 11, stall_o=0, no valid_o.
  - A start_i in cycle 11 completes normally at cycle 44.
- rst asserted at cycle 20 of an operation → all outputs 0 immediately, no valid_o after release; start_i+flush_i together in IDLE → no operation begins.
